// File: rtl/apb_master.sv
// APB master: turns a valid/ready request into one APB transfer (SETUP then ACCESS)
// and returns a single-cycle completion pulse, aborting after TIMEOUT wait cycles.
module apb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        PCLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic        PWRITE,
  output logic        PSELx,
  output logic        PENABLE,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  localparam bit         TimeoutEn  = (TIMEOUT != 0);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        accept, done_ok, done_to;

  logic        req_ready_q, req_ready_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // State and all output registers.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= 8'd0;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= 32'd0;
      pwdata_q      <= 32'd0;
      pstrb_q       <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Next state and wait counter; PREADY has priority over the timeout.
  always_comb begin
    accept  = (state_q == StIdle) && req_valid && req_ready_q;
    done_ok = (state_q == StAccess) && PREADY;
    done_to = (state_q == StAccess) && !PREADY && TimeoutEn && (wait_cnt_q == TimeoutCnt);
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (done_ok || done_to) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    wait_cnt_d = wait_cnt_q;
    if (state_q != StAccess) begin
      wait_cnt_d = 8'd0;
    end else if (!PREADY && wait_cnt_q != 8'hFF) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    req_ready_d   = (state_d == StIdle);
    psel_d        = (state_d != StIdle);
    penable_d     = (state_d == StAccess);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    if (accept) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pstrb_d  = req_write ? req_strb : 4'b0000;
    end
    rsp_valid_d   = done_ok || done_to;
    rsp_timeout_d = done_to;
    rsp_rdata_d   = (done_ok && !pwrite_q) ? PRDATA : 32'd0;
  end

  assign req_ready   = req_ready_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master (TIMEOUT=4): directed scenarios plus randomized
// transfers compared against a transfer-level reference model.
module tb_apb_master;

  localparam int unsigned TO = 4;

  logic        PCLK = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PWRITE, PSELx, PENABLE, PREADY;

  int vectors = 0;
  int miscompares = 0;

  apb_master #(.TIMEOUT(TO)) dut (
    .PCLK        (PCLK),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PWRITE      (PWRITE),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations of one transfer, filled in by run_xfer.
  int          obs_acc;
  logic        obs_setup_psel, obs_setup_pen, obs_setup_ready;
  logic [31:0] obs_paddr, obs_pwdata;
  logic [3:0]  obs_pstrb;
  logic        obs_pwrite, obs_stable, obs_early_rsp;
  logic        obs_rsp_valid, obs_rsp_to, obs_rsp_psel, obs_rsp_pen, obs_rsp_ready;
  logic [31:0] obs_rsp_rdata, obs_rsp_paddr;
  logic        obs_after_valid;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Reference model: number of ACCESS cycles and abort flag for a slave that raises
  // PREADY on ACCESS cycle index ready_at (negative = never).
  function automatic int exp_access(input int ready_at);
    if (ready_at < 0 || (TO != 0 && ready_at > int'(TO))) return int'(TO) + 1;
    return ready_at + 1;
  endfunction

  function automatic logic exp_abort(input int ready_at);
    return (ready_at < 0 || (TO != 0 && ready_at > int'(TO)));
  endfunction

  // Drives one request from IDLE and records what the bus and response did.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input int ready_at, input logic [31:0] rd);
    req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_valid = 1'b1;
    PREADY = 1'b1; PRDATA = $urandom;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_strb = 4'($urandom); req_write = 1'($urandom_range(0, 1));
    obs_setup_psel = PSELx; obs_setup_pen = PENABLE; obs_setup_ready = req_ready;
    obs_paddr = PADDR; obs_pwdata = PWDATA; obs_pstrb = PSTRB; obs_pwrite = PWRITE;
    step();
    obs_acc = 0; obs_stable = 1'b1; obs_early_rsp = 1'b0;
    while (PSELx && PENABLE && obs_acc < 300) begin
      if (PADDR !== obs_paddr || PWDATA !== obs_pwdata || PSTRB !== obs_pstrb ||
          PWRITE !== obs_pwrite) obs_stable = 1'b0;
      if (rsp_valid) obs_early_rsp = 1'b1;
      PREADY = (obs_acc == ready_at);
      PRDATA = PREADY ? rd : $urandom;
      obs_acc++;
      step();
    end
    obs_rsp_valid = rsp_valid; obs_rsp_to = rsp_timeout; obs_rsp_rdata = rsp_rdata;
    obs_rsp_psel = PSELx; obs_rsp_pen = PENABLE; obs_rsp_ready = req_ready;
    obs_rsp_paddr = PADDR;
    PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    step();
    obs_after_valid = rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; PREADY = 1'b1; PRDATA = $urandom;
    req_addr = $urandom; req_wdata = $urandom; req_strb = 4'hF; req_write = 1'b1;
    repeat (3) step();
    vectors++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_timeout, req_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl psel/pen/pwrite/rsp_valid/rsp_to/ready got %b exp 000000",
               {PSELx, PENABLE, PWRITE, rsp_valid, rsp_timeout, req_ready});
    end
    vectors++;
    if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data paddr %h pwdata %h pstrb %h rdata %h exp all 0",
               PADDR, PWDATA, PSTRB, rsp_rdata);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    step();
    vectors++;
    if (req_ready !== 1'b1 || PSELx !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready %b psel %b exp ready 1 psel 0", req_ready, PSELx);
    end
  endtask

  task automatic test_zero_wait_write();
    run_xfer(32'h0, 1'b1, 32'h41, 4'hF, 0, 32'hDEAD_BEEF);
    vectors++;
    if (obs_setup_psel !== 1'b1 || obs_setup_pen !== 1'b0 || obs_setup_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_setup psel %b pen %b ready %b exp 1 0 0",
               obs_setup_psel, obs_setup_pen, obs_setup_ready);
    end
    vectors++;
    if (obs_paddr !== 32'h0 || obs_pwdata !== 32'h41 || obs_pstrb !== 4'hF || obs_pwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL zw_bus addr %h wdata %h strb %h write %b exp 0 41 f 1",
               obs_paddr, obs_pwdata, obs_pstrb, obs_pwrite);
    end
    vectors++;
    if (obs_acc !== 1 || obs_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL zw_latency access_cycles %0d rsp_valid %b exp 1 1", obs_acc, obs_rsp_valid);
    end
    vectors++;
    if (obs_rsp_rdata !== 32'h0 || obs_rsp_to !== 1'b0 || obs_after_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_rsp rdata %h to %b next_valid %b exp 0 0 0",
               obs_rsp_rdata, obs_rsp_to, obs_after_valid);
    end
  endtask

  task automatic test_read_wait3();
    run_xfer(32'h4, 1'b0, $urandom, 4'hF, 3, 32'h0000_005A);
    vectors++;
    if (obs_pstrb !== 4'h0 || obs_pwrite !== 1'b0 || obs_paddr !== 32'h4) begin
      miscompares++;
      $display("FAIL rd3_bus strb %h write %b addr %h exp 0 0 4", obs_pstrb, obs_pwrite, obs_paddr);
    end
    vectors++;
    if (obs_acc !== 4 || obs_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL rd3_access cycles %0d stable %b exp 4 1", obs_acc, obs_stable);
    end
    vectors++;
    if (obs_rsp_valid !== 1'b1 || obs_rsp_rdata !== 32'h5A || obs_rsp_to !== 1'b0) begin
      miscompares++;
      $display("FAIL rd3_rsp valid %b rdata %h to %b exp 1 5a 0",
               obs_rsp_valid, obs_rsp_rdata, obs_rsp_to);
    end
  endtask

  task automatic test_timeout();
    run_xfer($urandom, 1'b0, $urandom, 4'hF, -1, 32'h1234_5678);
    vectors++;
    if (obs_acc !== 5) begin
      miscompares++;
      $display("FAIL to_access cycles got %0d exp 5", obs_acc);
    end
    vectors++;
    if (obs_rsp_valid !== 1'b1 || obs_rsp_to !== 1'b1 || obs_rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL to_rsp valid %b to %b rdata %h exp 1 1 0",
               obs_rsp_valid, obs_rsp_to, obs_rsp_rdata);
    end
    vectors++;
    if (obs_rsp_psel !== 1'b0 || obs_rsp_pen !== 1'b0 || obs_rsp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL to_bus psel %b pen %b ready %b exp 0 0 1",
               obs_rsp_psel, obs_rsp_pen, obs_rsp_ready);
    end
  endtask

  task automatic test_timeout_tie();
    run_xfer($urandom, 1'b0, $urandom, 4'hF, 4, 32'hCAFE_F00D);
    vectors++;
    if (obs_acc !== 5 || obs_rsp_valid !== 1'b1 || obs_rsp_to !== 1'b0 ||
        obs_rsp_rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL tie cycles %0d valid %b to %b rdata %h exp 5 1 0 cafef00d",
               obs_acc, obs_rsp_valid, obs_rsp_to, obs_rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_b, rd_b;
    addr_b = $urandom; rd_b = $urandom;
    req_addr = $urandom; req_write = 1'b1; req_wdata = $urandom; req_strb = 4'($urandom);
    req_valid = 1'b1; PREADY = 1'b0;
    step();
    req_addr = addr_b; req_write = 1'b0; req_wdata = $urandom; req_strb = 4'hF;
    step();
    PREADY = 1'b1; PRDATA = $urandom;
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || PSELx !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap rsp_valid %b ready %b psel %b exp 1 1 0", rsp_valid, req_ready, PSELx);
    end
    PREADY = 1'b0;
    step();
    req_valid = 1'b0;
    vectors++;
    if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PADDR !== addr_b || PSTRB !== 4'h0) begin
      miscompares++;
      $display("FAIL b2b_second psel %b pen %b addr %h strb %h exp 1 0 %h 0",
               PSELx, PENABLE, PADDR, PSTRB, addr_b);
    end
    step();
    PREADY = 1'b1; PRDATA = rd_b;
    step();
    PREADY = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== rd_b || rsp_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rsp valid %b rdata %h to %b exp 1 %h 0",
               rsp_valid, rsp_rdata, rsp_timeout, rd_b);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    rd = $urandom;
    req_addr = $urandom; req_write = 1'b0; req_wdata = $urandom; req_strb = 4'hF;
    req_valid = 1'b1; PREADY = 1'b0;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1; PREADY = 1'b1; PRDATA = $urandom;
    step();
    vectors++;
    if (PSELx !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort psel %b pen %b rsp_valid %b exp 0 0 0", PSELx, PENABLE, rsp_valid);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_recover ready %b rsp_valid %b exp 1 0", req_ready, rsp_valid);
    end
    run_xfer(32'h8, 1'b0, $urandom, 4'hF, 1, rd);
    vectors++;
    if (obs_acc !== 2 || obs_rsp_valid !== 1'b1 || obs_rsp_rdata !== rd || obs_rsp_to !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_next cycles %0d valid %b rdata %h to %b exp 2 1 %h 0",
               obs_acc, obs_rsp_valid, obs_rsp_rdata, obs_rsp_to, rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d, rd, exp_rdata;
      logic [3:0]  s, exp_strb;
      logic        w, exp_to;
      int          ready_at, exp_acc;
      a = $urandom; d = $urandom; rd = $urandom; s = 4'($urandom);
      w = 1'($urandom_range(0, 1));
      ready_at = int'($urandom_range(0, 7)) - 1;
      exp_acc   = exp_access(ready_at);
      exp_to    = exp_abort(ready_at);
      exp_strb  = w ? s : 4'h0;
      exp_rdata = (w || exp_to) ? 32'h0 : rd;
      repeat ($urandom_range(0, 2)) step();
      run_xfer(a, w, d, s, ready_at, rd);
      vectors++;
      if (obs_paddr !== a || obs_pwdata !== d || obs_pwrite !== w || obs_pstrb !== exp_strb) begin
        miscompares++;
        $display("FAIL rnd%0d_bus addr %h wdata %h write %b strb %h exp %h %h %b %h",
                 i, obs_paddr, obs_pwdata, obs_pwrite, obs_pstrb, a, d, w, exp_strb);
      end
      vectors++;
      if (obs_setup_psel !== 1'b1 || obs_setup_pen !== 1'b0 || obs_acc !== exp_acc ||
          obs_stable !== 1'b1 || obs_early_rsp !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_phases setup %b%b cycles %0d stable %b early %b exp 10 %0d 1 0",
                 i, obs_setup_psel, obs_setup_pen, obs_acc, obs_stable, obs_early_rsp, exp_acc);
      end
      vectors++;
      if (obs_rsp_valid !== 1'b1 || obs_rsp_to !== exp_to || obs_rsp_rdata !== exp_rdata ||
          obs_after_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_rsp valid %b to %b rdata %h next %b exp 1 %b %h 0",
                 i, obs_rsp_valid, obs_rsp_to, obs_rsp_rdata, obs_after_valid, exp_to, exp_rdata);
      end
      vectors++;
      if (obs_rsp_psel !== 1'b0 || obs_rsp_pen !== 1'b0 || obs_rsp_ready !== 1'b1 ||
          obs_rsp_paddr !== a) begin
        miscompares++;
        $display("FAIL rnd%0d_idle psel %b pen %b ready %b addr %h exp 0 0 1 %h",
                 i, obs_rsp_psel, obs_rsp_pen, obs_rsp_ready, obs_rsp_paddr, a);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_strb = 4'd0; PREADY = 1'b0; PRDATA = 32'd0;
    test_reset();
    test_zero_wait_write();
    test_read_wait3();
    test_timeout();
    test_timeout_tie();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
